// File: rtl/uart_fifo.sv
// uart_fifo: cpu32 peripheral-bus serial port.
// Contains a TX FIFO that feeds an 8N1/8N2 transmitter and a software-writable
// bit-rate divisor. An optional receiver is built when UART_RX_EN is defined.
// Register map: 0 DATA, 1 STATUS, 2 DIV, 3 IE. The bit period is DIV+1 clocks.
module uart_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int DIV_RESET  = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        wr_data, wr_div, wr_ie;
    logic [15:0] div_q;
    logic [15:0] div_wval;
    logic [1:0]  ie_q;
    logic        tx_idle;
    logic [15:0] status;
    logic [15:0] rd_mux;

    logic        rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]  rx_byte;

    assign wr_data  = we && (addr == 2'd0);
    assign wr_div   = we && (addr == 2'd2);
    assign wr_ie    = we && (addr == 2'd3);
    // Divisors below 3 leave too few clocks for the mid-bit RX sample; clamp them.
    assign div_wval = (wdata < 16'd3) ? 16'd3 : wdata;

    // Software-visible configuration registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= DIV_RESET[15:0];
            ie_q  <= 2'b00;
        end else begin
            if (wr_div) div_q <= div_wval;
            if (wr_ie)  ie_q  <= wdata[1:0];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Fullness is judged before any same-cycle pop, so a write at full is dropped.
    assign push       = wr_data && !fifo_full;

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage (no reset: contents are only read after being written)
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= wdata[7:0];
    end

    // ---------------- TX state machine ----------------
    state_t      tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic [2:0]  tx_bit, tx_bit_d;
    logic        tx_stop, tx_stop_d;
    logic        tx_d, tx_bit_end, tx_last_stop;

    assign tx_bit_end   = (tx_cnt == tx_div);
    assign tx_last_stop = (STOP_BITS == 1) ? 1'b1 : tx_stop;
    assign tx_idle      = fifo_empty && (tx_state == S_IDLE);

    // TX next state, FIFO pop and next serial level
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 16'd1;
        tx_div_d   = tx_div;
        tx_shift_d = tx_shift;
        tx_bit_d   = tx_bit;
        tx_stop_d  = tx_stop;
        pop        = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_d = 16'd0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr[AW-1:0]];
                    tx_div_d   = div_q;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_shift_d = {1'b0, tx_shift[7:1]};
                    tx_bit_d   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_stop_d  = 1'b0;
                        tx_state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = 16'd0;
                    if (!tx_last_stop) begin
                        tx_stop_d = 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain the next frame with no idle gap
                        pop        = 1'b1;
                        tx_shift_d = fifo_mem[rd_ptr[AW-1:0]];
                        tx_div_d   = div_q;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase

        tx_d = 1'b1;
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // TX control registers and the glitch-free registered pin
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_stop  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_stop  <= tx_stop_d;
            tx       <= tx_d;
        end
    end

    // TX datapath registers: shift register and frame-local divisor
    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_d;
        tx_div   <= tx_div_d;
    end

`ifdef UART_RX_EN
    // ---------------- RX ----------------
    logic        wr_status, rd_data_clr;
    logic        rx_p0, rx_p1, rx_prev;
    state_t      rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic [2:0]  rx_bit, rx_bit_d;
    logic        rx_deliver, rx_ferr_set, rx_accept;

    assign wr_status   = we && (addr == 2'd1);
    assign rd_data_clr = re && (addr == 2'd0);
    // A byte landing in the same cycle as a DATA read is accepted without overrun.
    assign rx_accept   = !rx_valid || rd_data_clr;

    // RX next state: falling-edge start detect, mid-bit sampling
    always_comb begin
        rx_state_d  = rx_state;
        rx_cnt_d    = rx_cnt + 16'd1;
        rx_div_d    = rx_div;
        rx_shift_d  = rx_shift;
        rx_bit_d    = rx_bit;
        rx_deliver  = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_prev && !rx_p1) begin
                    rx_div_d   = div_q;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt == (rx_div >> 1)) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_p1 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_p1, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_d    = 16'd0;
                    rx_state_d  = S_IDLE;
                    rx_ferr_set = !rx_p1;
                    rx_deliver  = rx_p1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX synchronizer, control state and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_p0        <= 1'b1;
            rx_p1        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= S_IDLE;
            rx_cnt       <= 16'd0;
            rx_bit       <= 3'd0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_p0    <= rx;
            rx_p1    <= rx_p0;
            rx_prev  <= rx_p1;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;

            if (rx_deliver)       rx_valid <= 1'b1;
            else if (rd_data_clr) rx_valid <= 1'b0;

            if (rx_deliver && !rx_accept)      rx_overrun <= 1'b1;
            else if (wr_status && wdata[3])    rx_overrun <= 1'b0;

            if (rx_ferr_set)                   rx_frame_err <= 1'b1;
            else if (wr_status && wdata[4])    rx_frame_err <= 1'b0;
        end
    end

    // RX datapath registers: shift register, frame-local divisor, received byte
    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_d;
        rx_div   <= rx_div_d;
        if (rx_deliver && rx_accept) rx_byte <= rx_shift;
    end
`else
    logic unused_rx;
    assign unused_rx    = rx;
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_byte      = 8'd0;
`endif

    assign status = {11'd0, rx_frame_err, rx_overrun, rx_valid, tx_idle, fifo_full};

    // Read-data select
    always_comb begin
        rd_mux = 16'd0;
        case (addr)
            2'd0:    rd_mux = {8'd0, rx_byte};
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = div_q;
            default: rd_mux = {14'd0, ie_q};
        endcase
    end

    // Registered read data and interrupt
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= 16'd0;
            irq   <= 1'b0;
        end else begin
            if (re) rdata <= rd_mux;
            irq <= (ie_q[0] & tx_idle) | (ie_q[1] & rx_valid);
        end
    end

endmodule
